// File: rtl/spi_aes_master_if.sv
// Host-side request/response bundle for spi_aes_master.
// The master modport is the host; the slave modport is the SPI master block itself.
interface spi_aes_master_if #(
   parameter int Nk = 4
);
   logic                start;
   logic [127:0]        data_in;
   logic [32*Nk-1:0]    key_in;
   logic [127:0]        data_out;
   logic                busy;
   logic                done;

   modport master (output start, data_in, key_in, input data_out, busy, done);
   modport slave  (input start, data_in, key_in, output data_out, busy, done);
endinterface

// File: rtl/spi_aes_master.sv
// Mode-0 SPI master: shifts out plaintext then key, idles GAP_BITS periods,
// then shifts in a 128-bit ciphertext from the AES slave.
module spi_aes_master #(
   parameter int Nk       = 4,
   parameter int CLK_DIV  = 2,
   parameter int GAP_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   spi_aes_master_if.slave     host,
   output logic                SCLK,
   output logic                MOSI,
   input  logic                MISO,
   output logic                CS
);
   localparam int TX_BITS = 128 + 32 * Nk;
   localparam int CNT_W   = $clog2(256 + 32 * Nk + GAP_BITS);
   localparam int DIV_W   = $clog2(CLK_DIV) + 1;

   localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_BITS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);
   localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(127);

   typedef enum logic [2:0] {IDLE, TX, GAP, RX, FIN} state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic [CNT_W-1:0]   bit_cnt;
   logic [TX_BITS-1:0] tx_sr;
   logic [127:0]       rx_sr;
   logic               in_xfer;
   logic               period_end;

   assign in_xfer    = (state == TX) || (state == GAP) || (state == RX);
   assign period_end = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: shift registers are cleared too, so an aborted transfer leaves no stale bits behind.
         state         <= IDLE;
         div_cnt       <= '0;
         bit_cnt       <= '0;
         tx_sr         <= '0;
         rx_sr         <= '0;
         CS            <= 1'b1;
         SCLK          <= 1'b0;
         MOSI          <= 1'b0;
         host.busy     <= 1'b0;
         host.done     <= 1'b0;
         host.data_out <= '0;
      end else begin
         // NOTE: pins are registered decodes of the current state, so they trail the state by one
         // cycle; that lag is what places the CS fall one edge after start is accepted.
         CS        <= !in_xfer;
         SCLK      <= in_xfer && (div_cnt >= DIV_HIGH);
         MOSI      <= (state == TX) && tx_sr[TX_BITS-1];
         host.busy <= in_xfer;
         host.done <= (state == FIN);
         if (state == FIN) host.data_out <= rx_sr;

         // Sample on the same edge that launches SCLK high.
         if (state == RX && div_cnt == DIV_HIGH) rx_sr <= {rx_sr[126:0], MISO};

         if (in_xfer) div_cnt <= period_end ? '0 : div_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (host.start) begin
                  tx_sr   <= {host.data_in, host.key_in};
                  rx_sr   <= '0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= TX;
               end
            end
            TX: begin
               if (period_end) begin
                  tx_sr <= tx_sr << 1;
                  if (bit_cnt == TX_LAST) begin
                     bit_cnt <= '0;
                     state   <= GAP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            GAP: begin
               if (period_end) begin
                  if (bit_cnt == GAP_LAST) begin
                     bit_cnt <= '0;
                     state   <= RX;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            RX: begin
               if (period_end) begin
                  if (bit_cnt == RX_LAST) begin
                     bit_cnt <= '0;
                     state   <= FIN;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_aes_master.sv
// Bench for spi_aes_master: four parameterisations share one SPI slave model
// that answers known AES vectors; results flow through an expected-value queue.
module tb_spi_aes_master;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam int GAP = 8;

   typedef struct {
      logic [127:0] ct;
      int           done_edge;
      int           rises;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start_r;
   logic [127:0] pt_r;
   logic [255:0] key_r;
   int           sel;
   logic         miso;
   logic [3:0]   sclk_v, cs_v, mosi_v;
   exp_t         sb[$];
   int           n_checks = 0;
   int           n_pass = 0;

   spi_aes_master_if #(.Nk(4)) if0 ();
   spi_aes_master_if #(.Nk(6)) if1 ();
   spi_aes_master_if #(.Nk(8)) if2 ();
   spi_aes_master_if #(.Nk(4)) if3 ();

   assign if0.start = start_r && (sel == 0);
   assign if1.start = start_r && (sel == 1);
   assign if2.start = start_r && (sel == 2);
   assign if3.start = start_r && (sel == 3);
   assign if0.data_in = pt_r;
   assign if1.data_in = pt_r;
   assign if2.data_in = pt_r;
   assign if3.data_in = pt_r;
   assign if0.key_in = key_r[127:0];
   assign if1.key_in = key_r[191:0];
   assign if2.key_in = key_r;
   assign if3.key_in = key_r[127:0];

   spi_aes_master #(.Nk(4), .CLK_DIV(2), .GAP_BITS(GAP)) u0 (
      .clk(clk), .rst(rst), .host(if0), .SCLK(sclk_v[0]), .MOSI(mosi_v[0]), .MISO(miso), .CS(cs_v[0]));
   spi_aes_master #(.Nk(6), .CLK_DIV(2), .GAP_BITS(GAP)) u1 (
      .clk(clk), .rst(rst), .host(if1), .SCLK(sclk_v[1]), .MOSI(mosi_v[1]), .MISO(miso), .CS(cs_v[1]));
   spi_aes_master #(.Nk(8), .CLK_DIV(2), .GAP_BITS(GAP)) u2 (
      .clk(clk), .rst(rst), .host(if2), .SCLK(sclk_v[2]), .MOSI(mosi_v[2]), .MISO(miso), .CS(cs_v[2]));
   spi_aes_master #(.Nk(4), .CLK_DIV(1), .GAP_BITS(GAP)) u3 (
      .clk(clk), .rst(rst), .host(if3), .SCLK(sclk_v[3]), .MOSI(mosi_v[3]), .MISO(miso), .CS(cs_v[3]));

   function automatic int nk_of(input int s);
      case (s)
         1:       return 6;
         2:       return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int div_of(input int s);
      return (s == 3) ? 1 : 2;
   endfunction

   // Stand-in for the AES slave: known FIPS-197 vectors, otherwise a simple reversible scramble.
   function automatic logic [127:0] ref_ct(input logic [127:0] pt, input logic [255:0] key, input int nk);
      logic [255:0] k;
      k = key & ((256'(1) << (32 * nk)) - 256'(1));
      if (pt == PT && k == (KEY256 >> (256 - 32 * nk))) begin
         case (nk)
            4:       return CT128;
            6:       return CT192;
            default: return CT256;
         endcase
      end
      return ~pt ^ k[127:0];
   endfunction

   logic         sclk_m, cs_m, mosi_m, done_m, busy_m;
   logic [127:0] dout_m;
   int           nk_m;

   always_comb begin
      sclk_m = sclk_v[sel[1:0]];
      cs_m   = cs_v[sel[1:0]];
      mosi_m = mosi_v[sel[1:0]];
      nk_m   = nk_of(sel);
      case (sel)
         1:       begin done_m = if1.done; busy_m = if1.busy; dout_m = if1.data_out; end
         2:       begin done_m = if2.done; busy_m = if2.busy; dout_m = if2.data_out; end
         3:       begin done_m = if3.done; busy_m = if3.busy; dout_m = if3.data_out; end
         default: begin done_m = if0.done; busy_m = if0.busy; dout_m = if0.data_out; end
      endcase
   end

   // SPI slave model (mode 0): captures MOSI on SCLK rise, drives MISO after SCLK fall.
   int           rise_cnt = 0;
   int           mosi_late = 0;
   int           cs_falls = 0;
   logic [383:0] rx_bits = '0;
   logic [127:0] slave_ct = '0;

   always @(negedge cs_m) begin
      rise_cnt  = 0;
      mosi_late = 0;
      rx_bits   = '0;
      cs_falls++;
   end

   always @(posedge sclk_m) begin
      if (!cs_m) begin
         if (rise_cnt < 128 + 32 * nk_m) rx_bits = {rx_bits[382:0], mosi_m};
         else if (mosi_m) mosi_late++;
         rise_cnt++;
         if (rise_cnt == 128 + 32 * nk_m)
            slave_ct = ref_ct(128'(rx_bits >> (32 * nk_m)), 256'(rx_bits), nk_m);
      end
   end

   always @(negedge sclk_m) begin : drive_miso
      int idx;
      idx = rise_cnt - (128 + 32 * nk_m) - GAP;
      if (!cs_m && idx >= 0 && idx < 128) miso = slave_ct[127-idx];
      else miso = 1'b0;
   end

   // Launches one transaction on the selected DUT from a negedge and checks it on done.
   task automatic run_txn(input int s, input logic [127:0] pt, input logic [255:0] key, input string name);
      exp_t e, got;
      int   n, cs_low, edge_seen;
      n           = 256 + 32 * nk_of(s) + GAP;
      sel         = s;
      e.ct        = ref_ct(pt, key, nk_of(s));
      e.done_edge = 1 + 2 * div_of(s) * n;
      e.rises     = n;
      sb.push_back(e);
      pt_r      = pt;
      key_r     = key;
      start_r   = 1'b1;
      cs_low    = 0;
      edge_seen = -1;
      for (int i = 0; i < e.done_edge + 100; i++) begin
         @(negedge clk);
         if (i == 0) start_r = 1'b0;
         if (done_m) begin
            edge_seen = i;
            break;
         end
         if (!cs_m) cs_low++;
      end
      got = sb.pop_front();
      n_checks++;
      if (edge_seen !== got.done_edge)
         $display("FAIL %s done_edge: got %0d expected %0d", name, edge_seen, got.done_edge);
      else n_pass++;
      n_checks++;
      if (dout_m !== got.ct) $display("FAIL %s data_out: got %h expected %h", name, dout_m, got.ct);
      else n_pass++;
      n_checks++;
      if (rise_cnt !== got.rises) $display("FAIL %s sclk_rises: got %0d expected %0d", name, rise_cnt, got.rises);
      else n_pass++;
      n_checks++;
      if (cs_low !== got.done_edge - 1)
         $display("FAIL %s cs_low_cycles: got %0d expected %0d", name, cs_low, got.done_edge - 1);
      else n_pass++;
   endtask

   task automatic test_reset();
      sel     = 0;
      start_r = 1'b0;
      pt_r    = '0;
      key_r   = '0;
      rst     = 1'b1;
      #2 rst  = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cs_v !== 4'hF) $display("FAIL reset cs: got %b expected 1111", cs_v); else n_pass++;
      n_checks++;
      if (sclk_v !== 4'h0 || mosi_v !== 4'h0)
         $display("FAIL reset sclk_mosi: got %b/%b expected 0000/0000", sclk_v, mosi_v);
      else n_pass++;
      n_checks++;
      if (if0.busy !== 1'b0 || if0.done !== 1'b0)
         $display("FAIL reset busy_done: got %b/%b expected 0/0", if0.busy, if0.done);
      else n_pass++;
      n_checks++;
      if (if0.data_out !== 128'h0) $display("FAIL reset data_out: got %h expected 0", if0.data_out);
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_aes128();
      run_txn(0, PT, KEY256 >> 128, "aes128");
   endtask

   task automatic test_mosi_order();
      logic [127:0] pt;
      logic [255:0] stream;
      pt = {1'b1, 126'h0, 1'b1};
      run_txn(0, pt, 256'h0, "mosi_order");
      stream = {pt, 128'h0};
      n_checks++;
      if (rx_bits[255:0] !== stream)
         $display("FAIL mosi_order stream: got %h expected %h", rx_bits[255:0], stream);
      else n_pass++;
      n_checks++;
      if (mosi_late !== 0) $display("FAIL mosi_order mosi_after_tx: got %0d expected 0", mosi_late);
      else n_pass++;
   endtask

   task automatic test_aes192_256();
      run_txn(1, PT, KEY256 >> 64, "aes192");
      run_txn(2, PT, KEY256, "aes256");
   endtask

   task automatic test_clk_div1();
      run_txn(3, PT, KEY256 >> 128, "clk_div1");
      run_txn(3, 128'hdeadbeef_01234567_89abcdef_55aa33cc, 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, "clk_div1_b");
   endtask

   task automatic test_start_while_busy();
      exp_t         ea, eb, got;
      logic [127:0] pt_a, pt_b;
      int           first_done, falls_at_done, second_low, second_done;
      pt_a  = 128'h0123456789abcdef_fedcba9876543210;
      pt_b  = 128'hcafef00d_12345678_9abcdef0_0badc0de;
      sel   = 0;
      key_r = 256'h0;
      key_r[127:0] = 128'h13579bdf_2468ace0_11223344_55667788;
      ea.ct = ref_ct(pt_a, key_r, 4); ea.done_edge = 1569; ea.rises = 392;
      eb.ct = ref_ct(pt_b, key_r, 4); eb.done_edge = 3139; eb.rises = 392;
      sb.push_back(ea);
      cs_falls      = 0;
      pt_r          = pt_a;
      start_r       = 1'b1;
      first_done    = -1;
      falls_at_done = -1;
      second_low    = -1;
      second_done   = -1;
      for (int i = 0; i < 3400; i++) begin
         @(negedge clk);
         if (i == 0 || i == 100) start_r = 1'b0;
         if (i == 99) start_r = 1'b1;
         if (i == 500) pt_r = pt_b;
         if (first_done >= 0 && i == first_done + 1) start_r = 1'b0;
         if (first_done >= 0 && second_low < 0 && !cs_m) second_low = i;
         if (done_m && first_done >= 0 && i > first_done) begin
            second_done = i;
            break;
         end
         if (done_m && first_done < 0) begin
            first_done    = i;
            falls_at_done = cs_falls;
            got = sb.pop_front();
            n_checks++;
            if (dout_m !== got.ct) $display("FAIL busy first_data: got %h expected %h", dout_m, got.ct);
            else n_pass++;
            sb.push_back(eb);
            start_r = 1'b1;
         end
      end
      n_checks++;
      if (first_done !== ea.done_edge) $display("FAIL busy first_done: got %0d expected %0d", first_done, ea.done_edge);
      else n_pass++;
      n_checks++;
      if (falls_at_done !== 1) $display("FAIL busy cs_falls: got %0d expected 1", falls_at_done);
      else n_pass++;
      n_checks++;
      if (second_low !== 1571) $display("FAIL busy second_cs_fall: got %0d expected 1571", second_low);
      else n_pass++;
      n_checks++;
      if (second_done !== eb.done_edge) $display("FAIL busy second_done: got %0d expected %0d", second_done, eb.done_edge);
      else n_pass++;
      got = sb.pop_front();
      n_checks++;
      if (dout_m !== got.ct) $display("FAIL busy second_data: got %h expected %h", dout_m, got.ct);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      sel     = 0;
      pt_r    = 128'h00ff00ff_00ff00ff_a5a5a5a5_5a5a5a5a;
      key_r   = 256'h0;
      start_r = 1'b1;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (i == 0) start_r = 1'b0;
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (cs_v[0] !== 1'b1 || sclk_v[0] !== 1'b0)
         $display("FAIL reset_mid cs_sclk: got %b/%b expected 1/0", cs_v[0], sclk_v[0]);
      else n_pass++;
      n_checks++;
      if (if0.busy !== 1'b0 || mosi_v[0] !== 1'b0)
         $display("FAIL reset_mid busy_mosi: got %b/%b expected 0/0", if0.busy, mosi_v[0]);
      else n_pass++;
      n_checks++;
      if (if0.data_out !== 128'h0) $display("FAIL reset_mid data_out: got %h expected 0", if0.data_out);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      run_txn(0, PT, KEY256 >> 128, "after_reset");
   endtask

   initial begin
      test_reset();
      test_aes128();
      test_mosi_order();
      test_aes192_256();
      test_clk_div1();
      test_start_while_busy();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
